// File: rtl/console_pkg.sv
// Shared geometry defaults, RGB333 type, attribute layout and colour palette
// for the text console renderer.
package console_pkg;

  localparam int unsigned COLS_DEFAULT    = 100;
  localparam int unsigned ROWS_DEFAULT    = 48;
  localparam int unsigned GLYPH_W_DEFAULT = 8;
  localparam int unsigned GLYPH_H_DEFAULT = 10;

  localparam int unsigned CoordW    = 10;
  localparam int unsigned CharAddrW = 13;
  localparam int unsigned FontAddrW = 12;
  localparam int unsigned ProdW     = 13;
  localparam int unsigned SubXW     = 3;
  localparam int unsigned SubYW     = 4;

  // Char RAM word layout: [7:0] code, [11:8] fg index, [15:12] bg index
  localparam int unsigned CodeLsb   = 0;
  localparam int unsigned CodeW     = 8;
  localparam int unsigned AttrFgLsb = 8;
  localparam int unsigned AttrBgLsb = 12;
  localparam int unsigned ColorIdxW = 4;

  typedef logic [8:0] rgb333_t;

  // {r[2:0], g[2:0], b[2:0]}; 0 = black, 15 = white
  localparam rgb333_t PALETTE [16] = '{
    9'h000, 9'h004, 9'h020, 9'h024, 9'h100, 9'h104, 9'h110, 9'h16D,
    9'h092, 9'h097, 9'h0BA, 9'h0BF, 9'h1D2, 9'h1D7, 9'h1FA, 9'h1FF
  };

  function automatic rgb333_t paletteLookup(input logic [ColorIdxW-1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/console_cell_counter.sv
// Generic cell/sub-cell counter for one screen axis. cell_c/sub_c are the
// position of the current pixel; the registers hold the previous one.
module console_cell_counter #(
  parameter int unsigned SPAN   = 8,
  parameter int unsigned CELL_W = 10,
  parameter int unsigned SUB_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              advance,
  output logic [CELL_W-1:0] cell_c,
  output logic [SUB_W-1:0]  sub_c
);

  logic [CELL_W-1:0] cellQ;
  logic [SUB_W-1:0]  subQ;

  always_comb begin
    cell_c = cellQ;
    sub_c  = subQ;
    if (restart) begin
      cell_c = '0;
      sub_c  = '0;
    end else if (advance) begin
      if (subQ == SUB_W'(SPAN - 1)) begin
        sub_c  = '0;
        cell_c = cellQ + CELL_W'(1);
      end else begin
        sub_c = subQ + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cellQ <= '0;
      subQ  <= '0;
    end else begin
      cellQ <= cell_c;
      subQ  <= sub_c;
    end
  end

endmodule

// File: rtl/text_console_renderer.sv
// Text-mode renderer: pixel coordinate -> char/font RAM reads -> RGB333 pixel,
// 3-clock latency. Optional blinking cursor via CONSOLE_CURSOR_EN.
module text_console_renderer
  import console_pkg::*;
#(
  parameter int unsigned COLS       = COLS_DEFAULT,
  parameter int unsigned ROWS       = ROWS_DEFAULT,
  parameter int unsigned GLYPH_W    = GLYPH_W_DEFAULT,
  parameter int unsigned GLYPH_H    = GLYPH_H_DEFAULT,
  parameter rgb333_t     BORDER_RGB = 9'h000
) (
  input  logic                 vgaClock,
  input  logic                 reset,
  input  logic [CoordW-1:0]    x,
  input  logic [CoordW-1:0]    y,
  input  logic                 active,
`ifdef CONSOLE_CURSOR_EN
  input  logic [6:0]           cursorCol,
  input  logic [5:0]           cursorRow,
  input  logic                 cursorOn,
`endif
  output logic [CharAddrW-1:0] addrRChar,
  input  logic [15:0]          dataChar,
  output logic [FontAddrW-1:0] addrRFont,
  input  logic [7:0]           dataFont,
  output rgb333_t              pixelData,
  output logic                 pixelValid
);

  localparam int unsigned CursorFirstLine = (GLYPH_H >= 2) ? GLYPH_H - 2 : 0;

  logic [CoordW-1:0] col_c, row_c;
  logic [SubXW-1:0]  subX_c;
  logic [SubYW-1:0]  subY_c;
  logic [CoordW-1:0] yPrev;
  logic              lineStart, inArea, cursorHit;
  logic [ProdW-1:0]  charIndex, fontIndex;

  // S1 / S2 pipeline registers
  logic [SubXW-1:0]     subXD1, subXD2;
  logic [SubYW-1:0]     subYD1;
  logic                 oobD1, oobD2, activeD1, activeD2, cursorD1, cursorD2;
  logic [ColorIdxW-1:0] fgD2, bgD2, fgSel, bgSel;
  logic                 glyphBit;
  rgb333_t              pixelNext;

  assign lineStart = (x == '0) && (y != yPrev);

  console_cell_counter #(.SPAN(GLYPH_W), .CELL_W(CoordW), .SUB_W(SubXW)) xCounter (
    .clk(vgaClock), .reset(reset), .restart(x == '0), .advance(1'b1),
    .cell_c(col_c), .sub_c(subX_c)
  );

  console_cell_counter #(.SPAN(GLYPH_H), .CELL_W(CoordW), .SUB_W(SubYW)) yCounter (
    .clk(vgaClock), .reset(reset), .restart(y == '0), .advance(lineStart),
    .cell_c(row_c), .sub_c(subY_c)
  );

  assign inArea    = (col_c < CoordW'(COLS)) && (row_c < CoordW'(ROWS));
  assign charIndex = ProdW'(row_c) * ProdW'(COLS) + ProdW'(col_c);
  assign fontIndex = ProdW'(dataChar[CodeLsb +: CodeW]) * ProdW'(GLYPH_H) + ProdW'(subYD1);

`ifdef CONSOLE_CURSOR_EN
  logic [4:0] frameCnt;

  // Blink phase: one count per frame, taken from the y wrap back to 0
  always_ff @(posedge vgaClock or posedge reset) begin
    if (reset) begin
      frameCnt <= '0;
    end else if ((y == '0) && (yPrev != '0)) begin
      frameCnt <= frameCnt + 5'(1);
    end
  end

  assign cursorHit = cursorOn && frameCnt[4] &&
                     (col_c == CoordW'(cursorCol)) && (row_c == CoordW'(cursorRow)) &&
                     (subY_c >= SubYW'(CursorFirstLine));
`else
  assign cursorHit = 1'b0;
`endif

  // RAM addresses are combinational so each read lands one stage later
  always_comb begin
    addrRChar = '0;
    addrRFont = '0;
    if (!reset) begin
      if (inArea) addrRChar = CharAddrW'(charIndex);
      addrRFont = FontAddrW'(fontIndex);
    end
  end

  always_ff @(posedge vgaClock or posedge reset) begin
    if (reset) begin
      yPrev    <= '0;
      subXD1   <= '0;
      subYD1   <= '0;
      oobD1    <= 1'b0;
      activeD1 <= 1'b0;
      cursorD1 <= 1'b0;
      subXD2   <= '0;
      oobD2    <= 1'b0;
      activeD2 <= 1'b0;
      cursorD2 <= 1'b0;
      fgD2     <= '0;
      bgD2     <= '0;
    end else begin
      yPrev    <= y;
      subXD1   <= subX_c;
      subYD1   <= subY_c;
      oobD1    <= !inArea;
      activeD1 <= active;
      cursorD1 <= cursorHit;
      subXD2   <= subXD1;
      oobD2    <= oobD1;
      activeD2 <= activeD1;
      cursorD2 <= cursorD1;
      fgD2     <= dataChar[AttrFgLsb +: ColorIdxW];
      bgD2     <= dataChar[AttrBgLsb +: ColorIdxW];
    end
  end

  // S2: glyph bit select (MSB leftmost) and palette lookup
  always_comb begin
    fgSel     = fgD2;
    bgSel     = bgD2;
    if (cursorD2) begin
      fgSel = bgD2;
      bgSel = fgD2;
    end
    glyphBit  = dataFont[SubXW'(3'd7 - subXD2)];
    pixelNext = BORDER_RGB;
    if (activeD2 && !oobD2) pixelNext = paletteLookup(glyphBit ? fgSel : bgSel);
  end

  always_ff @(posedge vgaClock or posedge reset) begin
    if (reset) begin
      pixelData  <= '0;
      pixelValid <= 1'b0;
    end else begin
      pixelData  <= pixelNext;
      pixelValid <= activeD2;
    end
  end

endmodule

// File: tb/tb_text_console_renderer.sv
// Scoreboard bench for text_console_renderer: stimulus queues expected pixels,
// a negedge monitor pops and compares them whenever pixelValid is high.
module tb_text_console_renderer;

  logic        vgaClock = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        active;
  logic [12:0] addrRChar;
  logic [15:0] dataChar;
  logic [11:0] addrRFont;
  logic [7:0]  dataFont;
  logic [8:0]  pixelData;
  logic        pixelValid;
`ifdef CONSOLE_CURSOR_EN
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;
  logic        cursorOn;
`endif

  always #5 vgaClock = ~vgaClock;

  text_console_renderer dut (
    .vgaClock(vgaClock), .reset(reset), .x(x), .y(y), .active(active),
`ifdef CONSOLE_CURSOR_EN
    .cursorCol(cursorCol), .cursorRow(cursorRow), .cursorOn(cursorOn),
`endif
    .addrRChar(addrRChar), .dataChar(dataChar),
    .addrRFont(addrRFont), .dataFont(dataFont),
    .pixelData(pixelData), .pixelValid(pixelValid)
  );

  // Uniform RAM contents per scenario, 1-cycle synchronous read
  logic [7:0] tCode, tAttr, tFont;
  always @(posedge vgaClock) begin
    dataChar <= {tAttr, tCode};
    dataFont <= tFont;
  end

  logic [8:0] pal [16] = '{9'h000, 9'h004, 9'h020, 9'h024, 9'h100, 9'h104, 9'h110, 9'h16D,
                           9'h092, 9'h097, 9'h0BA, 9'h0BF, 9'h1D2, 9'h1D7, 9'h1FA, 9'h1FF};

  typedef struct packed { logic chk; logic [8:0] pix; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference pixel: division-based cell lookup with optional cursor swap
  function automatic logic [8:0] expPix(input int px, input int py, input int frame, input bit cur);
    int col, sx, row, sy, fg, bg, t;
    logic b;
    col = px / 8; sx = px % 8; row = py / 10; sy = py % 10;
    if (col >= 100 || row >= 48) return 9'h000;
    b  = tFont[7 - sx];
    fg = int'(tAttr[3:0]);
    bg = int'(tAttr[7:4]);
    if (cur && col == 2 && row == 1 && sy >= 8 && frame >= 16 && frame < 32) begin
      t = fg; fg = bg; bg = t;
    end
    return b ? pal[fg] : pal[bg];
  endfunction

  task automatic drive(input int px, input int py, input logic act, input logic rst,
                       input logic chk, input logic [8:0] pix);
    @(posedge vgaClock); #1;
    reset  = rst;
    x      = 10'(px);
    y      = 10'(py);
    active = act;
    if (act && !rst) sbq.push_back('{chk, pix});
    @(negedge vgaClock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(int'(x), int'(y), 1'b0, 1'b0, 1'b0, 9'h000);
  endtask

  always @(negedge vgaClock) begin
    if (pixelValid) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_underflow: unexpected valid pixel %0h", pixelData);
      end else begin
        e = sbq.pop_front();
        if (e.chk) begin
          tests++;
          if (pixelData !== e.pix) begin
            fails++;
            $display("FAIL pixel: got %0h expected %0h at x=%0d y=%0d", pixelData, e.pix, x, y);
          end
        end
      end
    end else begin
      tests++;
      if (pixelData !== 9'h000) begin
        fails++;
        $display("FAIL invalid_border: got %0h expected 0", pixelData);
      end
    end
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; active = 1'b0;
    tCode = '0; tAttr = '0; tFont = '0;
`ifdef CONSOLE_CURSOR_EN
    cursorCol = 7'd2; cursorRow = 6'd1; cursorOn = 1'b0;
`endif
    repeat (3) @(negedge vgaClock);
    check("rst_pixelData", 32'(pixelData), 0);
    check("rst_pixelValid", 32'(pixelValid), 0);
    check("rst_addrRChar", 32'(addrRChar), 0);
    check("rst_addrRFont", 32'(addrRFont), 0);
    reset = 1'b0;

    // Glyph edges: fg white (F), bg black (0), font 1000_0001
    tCode = 8'h41; tAttr = 8'h0F; tFont = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      drive(i, 0, 1'b1, 1'b0, 1'b1, (i == 0 || i == 7) ? 9'h1FF : 9'h000);
      if (i == 1) check("font_addr_41", 32'(addrRFont), 650);
    end
    idle(4);

    // Solid fg then solid bg
    tAttr = 8'h1C; tFont = 8'hFF;
    for (int i = 0; i < 8; i++) drive(i, 0, 1'b1, 1'b0, 1'b1, 9'h1D2);
    idle(4);
    tFont = 8'h00;
    for (int i = 0; i < 8; i++) drive(i, 0, 1'b1, 1'b0, 1'b1, 9'h004);
    idle(4);

    // Right border at col 100
    for (int i = 0; i <= 801; i++) begin
      drive(i, 0, 1'b1, 1'b0, 1'b1, expPix(i, 0, 0, 0));
      if (i == 799) check("addr_col99", 32'(addrRChar), 99);
      if (i == 800) check("addr_col100", 32'(addrRChar), 0);
    end
    idle(4);

    // Bottom border at row 48
    for (int py = 1; py <= 480; py++) begin
      for (int px = 0; px <= 2; px++) begin
        drive(px, py, 1'b1, 1'b0, 1'b1, expPix(px, py, 0, 0));
        if (py == 479 && px == 0) check("addr_row47", 32'(addrRChar), 4700);
        if (py == 480 && px == 1) check("addr_row48", 32'(addrRChar), 0);
      end
    end
    idle(4);

    // Address arithmetic at y=25, x=16 with code 3
    tCode = 8'd3; tAttr = 8'h5A; tFont = 8'hC3;
    idle(4);
    for (int py = 0; py <= 25; py++) begin
      for (int px = 0; px <= ((py == 25) ? 17 : 2); px++) begin
        drive(px, py, 1'b1, 1'b0, 1'b1, expPix(px, py, 0, 0));
        if (py == 25 && px == 16) check("addr_char_202", 32'(addrRChar), 202);
        if (py == 25 && px == 17) check("addr_font_35", 32'(addrRFont), 35);
      end
    end
    idle(4);

    // Reset mid-line at x=300, release at x=310
    for (int px = 0; px < 300; px++) drive(px, 26, 1'b1, 1'b0, 1'b1, expPix(px, 26, 0, 0));
    for (int px = 300; px < 310; px++) begin
      @(posedge vgaClock); #1;
      reset = 1'b1; x = 10'(px); active = 1'b1;
      if (px == 300) sbq.delete();
      @(negedge vgaClock);
      check("midrst_pixelData", 32'(pixelData), 0);
      check("midrst_pixelValid", 32'(pixelValid), 0);
      check("midrst_addrRChar", 32'(addrRChar), 0);
    end
    for (int px = 310; px <= 320; px++) drive(px, 26, 1'b1, 1'b0, 1'b0, 9'h000);
    for (int px = 0; px <= 20; px++) begin
      drive(px, 0, 1'b1, 1'b0, 1'b1, expPix(px, 0, 0, 0));
      if (px == 16) check("resync_addr", 32'(addrRChar), 2);
    end
    idle(6);
    check("sb_drained_main", 32'(sbq.size()), 0);

`ifdef CONSOLE_CURSOR_EN
    // Cursor at (2,1): glyph lines 8..9 swapped only while frame bit 4 is set
    @(posedge vgaClock); #1; reset = 1'b1; x = '0; y = '0; active = 1'b0;
    @(negedge vgaClock); reset = 1'b0;
    tAttr = 8'h0F; tFont = 8'hFF; cursorOn = 1'b1;
    idle(4);
    for (int f = 0; f < 32; f++)
      for (int py = 0; py < 20; py++)
        for (int px = 0; px < 24; px++)
          drive(px, py, 1'b1, 1'b0, 1'b1, expPix(px, py, f, 1));
    idle(6);
    check("sb_drained_cursor", 32'(sbq.size()), 0);
`endif

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge vgaClock);
    check("sb_final_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
